// File: rtl/fp_pkg.sv
// Shared constants and FSM state type for the FP divider post-normalise/round stage.
package fp_pkg;
  localparam int unsigned FP32_BIAS       = 127;
  localparam int unsigned EXP_MAX         = 255;
  localparam logic [31:0] FP32_QNAN       = 32'h7FC00000;
  localparam int unsigned FP32_EXP_BITS   = 8;
  localparam int unsigned FP32_FRAC_BITS  = 23;
  localparam int unsigned DIV_EXP_W       = 10;
  localparam int unsigned DIV_MANT_W      = FP32_FRAC_BITS + 4;
  localparam int unsigned NORM_MAX_LSHIFT = 25;

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} norm_state_e;
endpackage

// File: rtl/fp_div_normalize_round_if.sv
// Input/output handshake bundle of the divider normalise/round stage.
interface fp_div_normalize_round_if #(
  parameter int unsigned EXP_W  = 10,
  parameter int unsigned MANT_W = 27
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic signed [EXP_W-1:0] in_exp;
  logic [MANT_W-1:0]       in_mant;
  logic                    in_nan;
  logic                    in_inf;
  logic                    in_zero;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             z;
  logic                    overflow;
  logic                    underflow;
  logic                    inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, in_zero, out_ready,
    input  in_ready, out_valid, z, overflow, underflow, inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, in_zero, out_ready,
    output in_ready, out_valid, z, overflow, underflow, inexact
  );
endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised fraction given guard and sticky bits.
module fp_round_rne #(
  parameter int unsigned FRAC_W = 23
) (
  input  logic [FRAC_W-1:0] frac,
  input  logic              guard,
  input  logic              sticky,
  output logic [FRAC_W-1:0] frac_rnd,
  output logic              carry,
  output logic              inexact
);
  logic              up;
  logic [FRAC_W:0]   sum;

  assign up       = guard & (sticky | frac[0]);
  assign sum      = {1'b0, frac} + {{FRAC_W{1'b0}}, up};
  // Carry out of the fraction means the significand rolled over to 2.0.
  assign frac_rnd = sum[FRAC_W-1:0];
  assign carry    = sum[FRAC_W];
  assign inexact  = guard | sticky;
endmodule

// File: rtl/fp_div_normalize_round.sv
// Post-divider stage: iterative one-bit-per-cycle normalisation, RNE rounding, binary32 packing.
module fp_div_normalize_round
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W  = DIV_EXP_W,
  parameter int unsigned FRAC_W = FP32_FRAC_BITS,
  parameter int unsigned MANT_W = DIV_MANT_W
) (
  input logic                    clk,
  input logic                    rst,
  fp_div_normalize_round_if.slave bus
);
  localparam logic signed [EXP_W-1:0] ExpOne  = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] ExpZero = '0;
  localparam logic signed [EXP_W-1:0] ExpTop  = EXP_W'(EXP_MAX);
  localparam logic [4:0]              LshMax  = 5'(NORM_MAX_LSHIFT);

  norm_state_e             state_q, state_d;
  logic                    sign_q, sign_d;
  logic signed [EXP_W-1:0] exp_q, exp_d;
  logic [MANT_W-1:0]       mant_q, mant_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [31:0]             z_q, z_d;
  logic                    ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

  logic [FRAC_W-1:0]       frac_rnd;
  logic                    rnd_carry, rnd_inexact;
  logic signed [EXP_W-1:0] exp_fin;

  fp_round_rne #(.FRAC_W(FRAC_W)) u_round (
    .frac     (mant_q[MANT_W-3:2]),
    .guard    (mant_q[1]),
    .sticky   (mant_q[0]),
    .frac_rnd (frac_rnd),
    .carry    (rnd_carry),
    .inexact  (rnd_inexact)
  );

  assign exp_fin = exp_q + (rnd_carry ? ExpOne : ExpZero);

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    inx_d   = inx_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          ovf_d = 1'b0;
          unf_d = 1'b0;
          inx_d = 1'b0;
          if (bus.in_nan) begin
            z_d     = FP32_QNAN;
            state_d = StDone;
          end else if (bus.in_inf) begin
            z_d     = {bus.in_sign, 8'hFF, 23'h0};
            state_d = StDone;
          end else if (bus.in_zero || bus.in_mant == '0) begin
            z_d     = {bus.in_sign, 31'h0};
            state_d = StDone;
          end else begin
            sign_d  = bus.in_sign;
            exp_d   = bus.in_exp;
            mant_d  = bus.in_mant;
            cnt_d   = '0;
            state_d = StNorm;
          end
        end
      end
      StNorm: begin
        if (mant_q[MANT_W-1]) begin
          // Shift out into the sticky position so no set bit is ever lost.
          mant_d = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
          exp_d  = exp_q + ExpOne;
        end else if (mant_q[MANT_W-2] || cnt_q == LshMax) begin
          state_d = StRound;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - ExpOne;
          cnt_d  = cnt_q + 5'd1;
        end
      end
      StRound: begin
        if (exp_fin >= ExpTop) begin
          z_d   = {sign_q, 8'hFF, 23'h0};
          ovf_d = 1'b1;
          inx_d = 1'b1;
        end else if (exp_fin <= ExpZero) begin
          z_d   = {sign_q, 31'h0};
          unf_d = 1'b1;
          inx_d = 1'b1;
        end else begin
          z_d   = {sign_q, exp_fin[7:0], frac_rnd};
          inx_d = rnd_inexact;
        end
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inx_q   <= inx_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.z         = z_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.inexact   = inx_q;
endmodule

// File: tb/tb_fp_div_normalize_round.sv
// Scoreboard bench: value-level reference model, random backpressure, latency and hold checks.
module tb_fp_div_normalize_round;
  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  fp_div_normalize_round_if #(.EXP_W(10), .MANT_W(27)) bus ();

  fp_div_normalize_round dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] z;
    logic [2:0]  flags;  // {overflow, underflow, inexact}
    int          lat;
    int          acc;
    bit          hold;
  } exp_t;

  exp_t sb[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Treats the mantissa as an integer with 25 fraction bits and rounds the value directly.
  function automatic exp_t model(input bit s, input int e_in, input logic [26:0] m,
                                 input bit nan, input bit inf, input bit zero);
    exp_t        r;
    int          e;
    int          p;
    int          shifts;
    logic [26:0] n;
    longint      sig;
    bit          g;
    bit          st;
    r.z = 0; r.flags = 0; r.lat = 1; r.acc = 0; r.hold = 0;
    e = e_in;
    if (nan) r.z = 32'h7FC00000;
    else if (inf) r.z = {s, 8'hFF, 23'h0};
    else if (zero || m == 0) r.z = {s, 31'h0};
    else begin
      p = 0;
      for (int i = 0; i < 27; i++) if (m[i]) p = i;
      if (p == 26) begin
        n = (m >> 1) | {26'h0, m[0]};
        e = e + 1;
        shifts = 1;
      end else begin
        shifts = 25 - p;
        n = m << shifts;
        e = e - shifts;
      end
      r.lat = 3 + shifts;
      sig = longint'(n[25:2]);
      g = n[1];
      st = n[0];
      if (g && (st || (sig % 2 == 1))) sig = sig + 1;
      if (sig == (longint'(1) << 24)) begin
        sig = sig >> 1;
        e = e + 1;
      end
      if (e >= 255) begin
        r.z = {s, 8'hFF, 23'h0};
        r.flags = 3'b101;
      end else if (e <= 0) begin
        r.z = {s, 31'h0};
        r.flags = 3'b011;
      end else begin
        r.z = {s, 8'(e), 23'(sig)};
        r.flags = {2'b00, g | st};
      end
    end
    return r;
  endfunction

  task automatic send(input bit s, input int e, input logic [26:0] m,
                      input bit nan, input bit inf, input bit zero, input bit hold);
    exp_t x;
    int   waited;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready) begin
      waited++;
      if (waited > 200) begin
        $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected 1", waited);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "in_ready never returned");
      end
      @(negedge clk);
    end
    bus.in_sign  = s;
    bus.in_exp   = 10'(e);
    bus.in_mant  = m;
    bus.in_nan   = nan;
    bus.in_inf   = inf;
    bus.in_zero  = zero;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    x = model(s, e, m, nan, inf, zero);
    x.acc = cyc;
    x.hold = hold;
    sb.push_back(x);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Monitor: compares every cycle out_valid is high, pops on handshake.
  initial begin
    bit   prev;
    bit   rdy;
    int   stall;
    exp_t e;
    prev = 0;
    stall = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 0;
        stall = 0;
        bus.out_ready = 1'b1;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
        if (bus.out_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got z=%h with no result outstanding", bus.z);
          end else begin
            e = sb[0];
            if (!prev) begin
              check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
              if (e.hold) stall = 5;
            end
            check("z", bus.z, e.z);
            check("flags", {29'h0, bus.overflow, bus.underflow, bus.inexact}, {29'h0, e.flags});
            if (stall > 0) begin
              rdy = 1'b0;
              stall--;
            end
            if (rdy) void'(sb.pop_front());
          end
        end
        bus.out_ready = rdy;
        prev = bus.out_valid;
      end
    end
  end

  initial begin
    int          e;
    int          w;
    int          kind;
    int          waited;
    logic [26:0] mask;
    logic [26:0] m;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sign = 1'b0;
    bus.in_exp = '0;
    bus.in_mant = '0;
    bus.in_nan = 1'b0;
    bus.in_inf = 1'b0;
    bus.in_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check("rst_z", bus.z, 32'h0);
    check("rst_flags", {29'h0, bus.overflow, bus.underflow, bus.inexact}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    send(0, 127, 27'h2000000, 0, 0, 0, 0);
    send(0, 127, 27'h4000000, 0, 0, 0, 0);
    send(0, 127, 27'h1000000, 0, 0, 0, 0);
    send(0, 127, 27'h3FFFFFE, 0, 0, 0, 0);
    send(0, 127, 27'h2000002, 0, 0, 0, 0);
    send(0, 127, 27'h2000006, 0, 0, 0, 0);
    send(0, 255, 27'h2000000, 0, 0, 0, 0);
    send(1, 0,   27'h2000000, 0, 0, 0, 0);
    send(0, 254, 27'h3FFFFFE, 0, 0, 0, 0);
    send(1, 1,   27'h0000001, 0, 0, 0, 0);
    send(0, 382, 27'h7FFFFFF, 0, 0, 0, 0);
    send(1, -127, 27'h4000001, 0, 0, 0, 0);
    send(0, 127, 27'h2000000, 1, 1, 1, 0);
    send(1, 127, 27'h2000000, 0, 1, 1, 0);
    send(1, 127, 27'h2000000, 0, 0, 1, 0);
    send(0, 127, 27'h0000000, 0, 0, 0, 0);
    send(1, 130, 27'h2ABCDEF, 0, 0, 0, 1);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 19);
      e = int'($urandom_range(0, 509)) - 127;
      w = $urandom_range(0, 27);
      mask = (w == 27) ? 27'h7FFFFFF : ((27'd1 << w) - 27'd1);
      m = 27'($urandom) & mask;
      send($urandom_range(0, 1) == 1, e, m, kind == 0, kind == 1, kind == 2,
           $urandom_range(0, 15) == 0);
    end

    waited = 0;
    while (sb.size() != 0 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d results outstanding expected 0", sb.size());
      sb.delete();
    end

    // Reset in the middle of a long normalisation must discard the operation.
    send(0, 127, 27'h0000001, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    sb.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    check("midrst_z", bus.z, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_output", {31'h0, bus.out_valid}, 32'd0);

    send(0, 127, 27'h1000000, 0, 0, 0, 0);
    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL post_reset_op: got %0d results outstanding expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
